// File: rtl/mii_rx_framer.sv
// MII/GMII receive framer: oversamples the PHY pins in the clk domain, strips the
// preamble and SFD, assembles bytes, extracts the Ethernet header and keeps frame statistics.
module mii_rx_framer #(
  parameter int          DATA_W   = 4,
  parameter int          MIN_PRE  = 2,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518,
  parameter logic [47:0] MAC_ADDR = 48'h54_ff_01_21_23_24
) (
  input  logic              clk,
  input  logic              SW0,
  input  logic              mii_clk,
  input  logic              mii_en,
  input  logic [DATA_W-1:0] mii_d,
  input  logic              promisc,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_err,
  output logic [47:0]       hdr_dst,
  output logic [47:0]       hdr_src,
  output logic [15:0]       hdr_type,
  output logic              hdr_valid,
  output logic              addr_match,
  output logic [10:0]       frame_len,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_bad
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [7:0]  PRE_VAL   = (DATA_W == 8) ? 8'h55 : 8'h05;
  localparam logic [7:0]  SFD_VAL   = (DATA_W == 8) ? 8'hD5 : 8'h0D;
  localparam logic [7:0]  MIN_PRE_C = 8'(MIN_PRE);
  localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);

  logic [1:0]        clk_sync, en_sync;
  logic [DATA_W-1:0] d_sync1, d_sync2;
  logic              clk_hist;
  logic              sample, en_s;
  logic [7:0]        d_ext, byte_in;

  state_t      state, next_state;
  logic [7:0]  pre_cnt;
  logic [11:0] byte_cnt;
  logic        phase;
  logic [3:0]  low_nib;
  logic [47:0] dst_sh, src_sh;
  logic [7:0]  type_hi;

  logic pre_start, pre_inc, pre_err, enter_data, store_low, emit, end_frame, end_err;

  // Data and enable ride the same two-stage pipeline as mii_clk so they are
  // aligned with the detected rising edge.
  // NOTE: every clocked register uses <= so all flops see pre-edge values.
  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      clk_sync <= '0;
      en_sync  <= '0;
      d_sync1  <= '0;
      d_sync2  <= '0;
      clk_hist <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], mii_clk};
      en_sync  <= {en_sync[0], mii_en};
      d_sync1  <= mii_d;
      d_sync2  <= d_sync1;
      clk_hist <= clk_sync[1];
    end
  end

  assign sample  = clk_sync[1] & ~clk_hist;
  assign en_s    = en_sync[1];
  assign d_ext   = 8'(d_sync2);
  assign byte_in = (DATA_W == 8) ? d_ext : {d_ext[3:0], low_nib};

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    pre_start  = 1'b0;
    pre_inc    = 1'b0;
    pre_err    = 1'b0;
    enter_data = 1'b0;
    store_low  = 1'b0;
    emit       = 1'b0;
    end_frame  = 1'b0;
    end_err    = 1'b0;
    if (sample) begin
      unique case (state)
        IDLE: if (en_s) begin
          if (d_ext == PRE_VAL) begin next_state = PRE;  pre_start = 1'b1; end
          else                  begin next_state = DROP; pre_err   = 1'b1; end
        end
        PRE: begin
          if (!en_s)                begin next_state = IDLE; pre_err = 1'b1; end
          else if (d_ext == PRE_VAL) pre_inc = 1'b1;
          else if (d_ext == SFD_VAL && pre_cnt >= MIN_PRE_C) begin
            next_state = DATA;
            enter_data = 1'b1;
          end else                  begin next_state = DROP; pre_err = 1'b1; end
        end
        DATA: begin
          if (!en_s) begin
            end_frame  = 1'b1;
            end_err    = (byte_cnt < MIN_LEN_C) || phase;
            next_state = IDLE;
          end else if (DATA_W == 4 && !phase) begin
            store_low = 1'b1;
          end else if (byte_cnt == MAX_LEN_C) begin
            // Byte MAX_LEN+1 is swallowed; the rest of the frame is dropped.
            end_frame  = 1'b1;
            end_err    = 1'b1;
            next_state = DROP;
          end else begin
            emit = 1'b1;
          end
        end
        DROP: if (!en_s) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_err    <= 1'b0;
      hdr_dst    <= '0;
      hdr_src    <= '0;
      hdr_type   <= '0;
      hdr_valid  <= 1'b0;
      addr_match <= 1'b0;
      frame_len  <= '0;
      frames_ok  <= '0;
      frames_bad <= '0;
      pre_cnt    <= '0;
      byte_cnt   <= '0;
      phase      <= 1'b0;
      low_nib    <= '0;
      dst_sh     <= '0;
      src_sh     <= '0;
      type_hi    <= '0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && (byte_cnt == 12'd0);
      out_eof   <= end_frame;
      out_err   <= end_frame && end_err;
      hdr_valid <= emit && (byte_cnt == 12'd13);

      if (pre_start)                     pre_cnt <= 8'd1;
      else if (pre_inc && pre_cnt != '1) pre_cnt <= pre_cnt + 8'd1;

      if (enter_data) begin
        byte_cnt <= '0;
        phase    <= 1'b0;
      end
      if (store_low) begin
        low_nib <= d_ext[3:0];
        phase   <= 1'b1;
      end

      if (emit) begin
        out_data <= byte_in;
        phase    <= 1'b0;
        byte_cnt <= byte_cnt + 12'd1;
        // Header shadows keep the published fields stable until the next hdr_valid.
        if (byte_cnt < 12'd6)       dst_sh  <= {dst_sh[39:0], byte_in};
        else if (byte_cnt < 12'd12) src_sh  <= {src_sh[39:0], byte_in};
        else if (byte_cnt == 12'd12) type_hi <= byte_in;
        else if (byte_cnt == 12'd13) begin
          hdr_dst    <= dst_sh;
          hdr_src    <= src_sh;
          hdr_type   <= {type_hi, byte_in};
          addr_match <= promisc || (dst_sh == MAC_ADDR) || (dst_sh == 48'hFFFF_FFFF_FFFF);
        end
      end

      if (end_frame) begin
        frame_len <= (byte_cnt > 12'd2047) ? 11'h7FF : byte_cnt[10:0];
        if (!end_err && frames_ok != '1) frames_ok <= frames_ok + 16'd1;
      end
      if (((end_frame && end_err) || pre_err) && frames_bad != '1)
        frames_bad <= frames_bad + 16'd1;
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Scoreboard bench for mii_rx_framer: nibble instance, nibble instance with MAX_LEN=100,
// and byte-mode instance, all checked against expectations queued at stimulus time.
module tb_mii_rx_framer;

  localparam logic [47:0] MAC   = 48'h54_ff_01_21_23_24;
  localparam logic [47:0] SRC   = 48'h12_34_56_78_9a_bc;
  localparam logic [47:0] OTHER = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [15:0] ETYPE = 16'h1234;

  typedef struct packed { logic [7:0] data; logic sof; } byte_t;
  typedef struct packed { logic err; logic [10:0] len; logic chk_len; } eof_t;
  typedef struct packed { logic [47:0] dst; logic [47:0] src; logic [15:0] typ; logic match; } hdr_t;

  logic clk = 1'b0, SW0 = 1'b1, promisc = 1'b0;
  logic mii_clk4 = 1'b0, mii_en4 = 1'b0, mii_clk8 = 1'b0, mii_en8 = 1'b0;
  logic [3:0] mii_d4 = '0;
  logic [7:0] mii_d8 = '0;

  logic [2:0]        out_valid, out_sof, out_eof, out_err, hdr_valid, addr_match;
  logic [2:0][7:0]   out_data;
  logic [2:0][47:0]  hdr_dst, hdr_src;
  logic [2:0][15:0]  hdr_type, frames_ok, frames_bad;
  logic [2:0][10:0]  frame_len;

  byte_t exp_bytes[3][$];
  eof_t  exp_eof[3][$];
  hdr_t  exp_hdr[3][$];
  int    exp_ok[3], exp_bad[3];
  int    n_checks = 0, n_fail = 0;
  logic [7:0] fr[$];
  string msg = "Twas' on the good ship Venus...";

  always #5 clk = ~clk;

  mii_rx_framer dut_a (
    .clk(clk), .SW0(SW0), .mii_clk(mii_clk4), .mii_en(mii_en4), .mii_d(mii_d4), .promisc(promisc),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_sof(out_sof[0]), .out_eof(out_eof[0]),
    .out_err(out_err[0]), .hdr_dst(hdr_dst[0]), .hdr_src(hdr_src[0]), .hdr_type(hdr_type[0]),
    .hdr_valid(hdr_valid[0]), .addr_match(addr_match[0]), .frame_len(frame_len[0]),
    .frames_ok(frames_ok[0]), .frames_bad(frames_bad[0]));

  mii_rx_framer #(.MAX_LEN(100)) dut_m (
    .clk(clk), .SW0(SW0), .mii_clk(mii_clk4), .mii_en(mii_en4), .mii_d(mii_d4), .promisc(promisc),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_sof(out_sof[1]), .out_eof(out_eof[1]),
    .out_err(out_err[1]), .hdr_dst(hdr_dst[1]), .hdr_src(hdr_src[1]), .hdr_type(hdr_type[1]),
    .hdr_valid(hdr_valid[1]), .addr_match(addr_match[1]), .frame_len(frame_len[1]),
    .frames_ok(frames_ok[1]), .frames_bad(frames_bad[1]));

  mii_rx_framer #(.DATA_W(8)) dut_b (
    .clk(clk), .SW0(SW0), .mii_clk(mii_clk8), .mii_en(mii_en8), .mii_d(mii_d8), .promisc(promisc),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_sof(out_sof[2]), .out_eof(out_eof[2]),
    .out_err(out_err[2]), .hdr_dst(hdr_dst[2]), .hdr_src(hdr_src[2]), .hdr_type(hdr_type[2]),
    .hdr_valid(hdr_valid[2]), .addr_match(addr_match[2]), .frame_len(frame_len[2]),
    .frames_ok(frames_ok[2]), .frames_bad(frames_bad[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input int len);
    fr.delete();
    for (int k = 0; k < 6; k++) fr.push_back(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) fr.push_back(SRC[47-8*k -: 8]);
    fr.push_back(ETYPE[15:8]);
    fr.push_back(ETYPE[7:0]);
    for (int k = 14; k < len; k++) fr.push_back(msg[(k-14) % msg.len()]);
  endtask

  // cut > 0 queues only the first cut bytes and the header (frame aborted by reset).
  task automatic expect_frame(input int i, input int max_len, input logic odd,
                              input logic match, input int cut);
    int    n;
    logic  over, err;
    hdr_t  h;
    n    = (fr.size() > max_len) ? max_len : fr.size();
    if (cut > 0) n = cut;
    over = fr.size() > max_len;
    err  = over || (fr.size() < 64) || odd;
    for (int k = 0; k < n; k++) exp_bytes[i].push_back('{fr[k], k == 0});
    if (n >= 14) begin
      h = '{48'd0, 48'd0, 16'd0, match};
      for (int k = 0; k < 6; k++)  h.dst = {h.dst[39:0], fr[k]};
      for (int k = 6; k < 12; k++) h.src = {h.src[39:0], fr[k]};
      h.typ = {fr[12], fr[13]};
      exp_hdr[i].push_back(h);
    end
    if (cut == 0) begin
      exp_eof[i].push_back('{err, 11'(n), !over});
      if (err) exp_bad[i]++;
      else     exp_ok[i]++;
    end
  endtask

  task automatic nib(input logic en, input logic [3:0] d);
    mii_en4 = en;
    mii_d4  = d;
    #20 mii_clk4 = 1'b1;
    #20 mii_clk4 = 1'b0;
  endtask

  task automatic byt(input logic en, input logic [7:0] d);
    mii_en8 = en;
    mii_d8  = d;
    #20 mii_clk8 = 1'b1;
    #20 mii_clk8 = 1'b0;
  endtask

  task automatic send4(input int npre, input logic odd, input int nbytes, input logic close);
    logic [7:0] b;
    @(posedge clk); #2;
    repeat (npre) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    for (int k = 0; k < nbytes; k++) begin
      b = fr[k];
      nib(1'b1, b[3:0]);
      nib(1'b1, b[7:4]);
    end
    if (odd)   nib(1'b1, 4'h7);
    if (close) repeat (4) nib(1'b0, 4'h0);
  endtask

  task automatic send8();
    @(posedge clk); #2;
    repeat (7) byt(1'b1, 8'h55);
    byt(1'b1, 8'hD5);
    foreach (fr[k]) byt(1'b1, fr[k]);
    repeat (4) byt(1'b0, 8'h00);
  endtask

  task automatic chk_stats(input int i);
    check($sformatf("frames_ok%0d", i),  frames_ok[i],  16'(exp_ok[i]));
    check($sformatf("frames_bad%0d", i), frames_bad[i], 16'(exp_bad[i]));
    check($sformatf("bytes_left%0d", i), exp_bytes[i].size(), 0);
    check($sformatf("eof_left%0d", i),   exp_eof[i].size(), 0);
    check($sformatf("hdr_left%0d", i),   exp_hdr[i].size(), 0);
  endtask

  task automatic chk_zero(input int i);
    check($sformatf("rst_valid%0d", i), {out_valid[i], out_sof[i], out_eof[i], out_err[i],
                                         hdr_valid[i], addr_match[i]}, 0);
    check($sformatf("rst_hdr%0d", i),   hdr_dst[i] | hdr_src[i] | 48'(hdr_type[i]), 0);
    check($sformatf("rst_len%0d", i),   frame_len[i], 0);
    check($sformatf("rst_cnt%0d", i),   {frames_ok[i], frames_bad[i]}, 0);
  endtask

  always @(negedge clk) begin : monitor
    byte_t eb;
    eof_t  ee;
    hdr_t  eh;
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i]) begin
        check($sformatf("byte_expected%0d", i), exp_bytes[i].size() != 0, 1);
        if (exp_bytes[i].size() != 0) begin
          eb = exp_bytes[i].pop_front();
          check($sformatf("out_data%0d", i), out_data[i], eb.data);
          check($sformatf("out_sof%0d", i),  out_sof[i],  eb.sof);
        end
      end
      if (out_eof[i]) begin
        check($sformatf("eof_expected%0d", i), exp_eof[i].size() != 0, 1);
        check($sformatf("eof_valid_low%0d", i), out_valid[i], 0);
        if (exp_eof[i].size() != 0) begin
          ee = exp_eof[i].pop_front();
          check($sformatf("out_err%0d", i), out_err[i], ee.err);
          if (ee.chk_len) check($sformatf("frame_len%0d", i), frame_len[i], ee.len);
        end
      end
      if (hdr_valid[i]) begin
        check($sformatf("hdr_expected%0d", i), exp_hdr[i].size() != 0, 1);
        if (exp_hdr[i].size() != 0) begin
          eh = exp_hdr[i].pop_front();
          check($sformatf("hdr_dst%0d", i),    hdr_dst[i],    eh.dst);
          check($sformatf("hdr_src%0d", i),    hdr_src[i],    eh.src);
          check($sformatf("hdr_type%0d", i),   hdr_type[i],   eh.typ);
          check($sformatf("addr_match%0d", i), addr_match[i], eh.match);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i);
    SW0 = 1'b0;

    // 50-byte runt addressed to this station
    build(MAC, 50);
    expect_frame(0, 1518, 1'b0, 1'b1, 0);
    expect_frame(1, 100, 1'b0, 1'b1, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);

    // Minimum-length good frames: own address, foreign, foreign+promisc, broadcast
    build(MAC, 64);
    expect_frame(0, 1518, 1'b0, 1'b1, 0);
    expect_frame(1, 100, 1'b0, 1'b1, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);

    build(OTHER, 64);
    expect_frame(0, 1518, 1'b0, 1'b0, 0);
    expect_frame(1, 100, 1'b0, 1'b0, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);

    promisc = 1'b1;
    expect_frame(0, 1518, 1'b0, 1'b1, 0);
    expect_frame(1, 100, 1'b0, 1'b1, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);
    promisc = 1'b0;

    build(BCAST, 64);
    expect_frame(0, 1518, 1'b0, 1'b1, 0);
    expect_frame(1, 100, 1'b0, 1'b1, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);

    // 120-byte frame: fine for the default instance, oversize for MAX_LEN=100
    build(MAC, 120);
    expect_frame(0, 1518, 1'b0, 1'b1, 0);
    expect_frame(1, 100, 1'b0, 1'b1, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);

    // 64 bytes plus one stray nibble
    build(MAC, 64);
    expect_frame(0, 1518, 1'b1, 1'b1, 0);
    expect_frame(1, 100, 1'b1, 1'b1, 0);
    send4(15, 1'b1, fr.size(), 1'b1);
    chk_stats(0); chk_stats(1);

    // SFD after a single preamble nibble: dropped silently, counted bad
    send4(1, 1'b0, fr.size(), 1'b1);
    exp_bad[0]++;
    exp_bad[1]++;
    chk_stats(0); chk_stats(1);

    // Byte mode, same 64-byte frame
    expect_frame(2, 1518, 1'b0, 1'b1, 0);
    send8();
    chk_stats(2);

    // Reset mid-frame after 20 bytes
    expect_frame(0, 1518, 1'b0, 1'b1, 20);
    expect_frame(1, 100, 1'b0, 1'b1, 20);
    send4(15, 1'b0, 20, 1'b0);
    repeat (8) @(posedge clk);
    #2 SW0 = 1'b1;
    mii_en4 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_zero(i);
      exp_ok[i]  = 0;
      exp_bad[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2 SW0 = 1'b0;
    for (int i = 0; i < 3; i++) chk_stats(i);

    // Next good frame after the reset
    expect_frame(0, 1518, 1'b0, 1'b1, 0);
    expect_frame(1, 100, 1'b0, 1'b1, 0);
    send4(15, 1'b0, fr.size(), 1'b1);
    for (int i = 0; i < 3; i++) chk_stats(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
